// File: rtl/crop_box_downscaler_if.sv
// Pixel-stream bundle for crop_box_downscaler: camera-side input pixels in,
// downscaled pixels with their output coordinates out.
interface crop_box_downscaler_if #(
  parameter int CHANNELS   = 3,
  parameter int CH_WIDTH   = 8,
  parameter int OUT_WIDTH  = 224,
  parameter int OUT_HEIGHT = 224
);
  localparam int DATA_W = CHANNELS * CH_WIDTH;
  localparam int COL_W  = (OUT_WIDTH  > 1) ? $clog2(OUT_WIDTH)  : 1;
  localparam int ROW_W  = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              start_frame;
  logic              mode;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [COL_W-1:0]  out_col;
  logic [ROW_W-1:0]  out_row;
  logic              end_of_frame;

  modport master (
    output in_data, in_valid, start_frame, mode,
    input  out_data, out_valid, out_col, out_row, end_of_frame
  );

  modport slave (
    input  in_data, in_valid, start_frame, mode,
    output out_data, out_valid, out_col, out_row, end_of_frame
  );
endinterface

// File: rtl/crop_box_downscaler.sv
// Crops a window out of a raster-scan pixel stream and reduces each S x S block to
// one pixel, either as a rounded box average or by keeping the block's top-left sample.
module crop_box_downscaler #(
  parameter int CHANNELS     = 3,
  parameter int CH_WIDTH     = 8,
  parameter int INPUT_WIDTH  = 640,
  parameter int INPUT_HEIGHT = 480,
  parameter int CROP_TOP     = 16,
  parameter int CROP_LEFT    = 96,
  parameter int SCALE_LOG2   = 1,
  parameter int OUT_WIDTH    = 224,
  parameter int OUT_HEIGHT   = 224
) (
  input logic             clock,
  input logic             reset_n,
  crop_box_downscaler_if.slave bus
);
  localparam int S         = 1 << SCALE_LOG2;
  localparam int SHIFT     = 2 * SCALE_LOG2;
  localparam int ACC_W     = CH_WIDTH + SHIFT + 1;
  localparam int DATA_W    = CHANNELS * CH_WIDTH;
  localparam int IN_COL_W  = (INPUT_WIDTH  > 1) ? $clog2(INPUT_WIDTH)  : 1;
  localparam int IN_ROW_W  = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1;
  localparam int OUT_COL_W = (OUT_WIDTH    > 1) ? $clog2(OUT_WIDTH)    : 1;
  localparam int OUT_ROW_W = (OUT_HEIGHT   > 1) ? $clog2(OUT_HEIGHT)   : 1;

  localparam logic [IN_COL_W-1:0]  COL_LO       = IN_COL_W'(CROP_LEFT);
  localparam logic [IN_COL_W-1:0]  COL_HI       = IN_COL_W'(CROP_LEFT + OUT_WIDTH * S - 1);
  localparam logic [IN_COL_W-1:0]  COL_MAX      = IN_COL_W'(INPUT_WIDTH - 1);
  localparam logic [IN_COL_W-1:0]  COL_MASK     = IN_COL_W'(S - 1);
  localparam logic [IN_ROW_W-1:0]  ROW_LO       = IN_ROW_W'(CROP_TOP);
  localparam logic [IN_ROW_W-1:0]  ROW_HI       = IN_ROW_W'(CROP_TOP + OUT_HEIGHT * S - 1);
  localparam logic [IN_ROW_W-1:0]  ROW_MAX      = IN_ROW_W'(INPUT_HEIGHT - 1);
  localparam logic [IN_ROW_W-1:0]  ROW_MASK     = IN_ROW_W'(S - 1);
  localparam logic [OUT_COL_W-1:0] OUT_COL_LAST = OUT_COL_W'(OUT_WIDTH - 1);
  localparam logic [OUT_ROW_W-1:0] OUT_ROW_LAST = OUT_ROW_W'(OUT_HEIGHT - 1);
  localparam logic [ACC_W-1:0]     ROUND        = ACC_W'((1 << SHIFT) >> 1);

  generate
    if (SCALE_LOG2 < 0 || SCALE_LOG2 > 3) begin : g_bad_scale
      $error("crop_box_downscaler: SCALE_LOG2 must be in 0..3");
    end
    if (CROP_TOP + OUT_HEIGHT * S > INPUT_HEIGHT ||
        CROP_LEFT + OUT_WIDTH * S > INPUT_WIDTH) begin : g_bad_window
      $error("crop_box_downscaler: crop window exceeds the input frame");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                state;
  logic [IN_ROW_W-1:0]   inRow;
  logic [IN_COL_W-1:0]   inCol;
  logic                  modeLatched;
  logic [ACC_W-1:0]      lineAcc [OUT_WIDTH][CHANNELS];

  logic                  outValid;
  logic                  endOfFrame;
  logic [DATA_W-1:0]     outData;
  logic [OUT_COL_W-1:0]  outCol;
  logic [OUT_ROW_W-1:0]  outRow;

  // Pixel decode: a start_frame pixel is always input (0,0) of the new frame.
  logic                  restart, accept, inWindow, hit, emit, finalBlock;
  logic                  firstSample, lastSample, effMode;
  logic [IN_ROW_W-1:0]   curRow, relRow, nextRow;
  logic [IN_COL_W-1:0]   curCol, relCol, nextCol;
  logic [OUT_ROW_W-1:0]  blockRow;
  logic [OUT_COL_W-1:0]  blockCol;

  assign restart  = bus.start_frame;
  assign accept   = bus.in_valid && (restart || state == ACTIVE);
  assign curRow   = restart ? '0 : inRow;
  assign curCol   = restart ? '0 : inCol;
  assign relRow   = curRow - ROW_LO;
  assign relCol   = curCol - COL_LO;
  assign inWindow = (curRow >= ROW_LO) && (curRow <= ROW_HI) &&
                    (curCol >= COL_LO) && (curCol <= COL_HI);
  assign blockRow = OUT_ROW_W'(relRow >> SCALE_LOG2);
  assign blockCol = OUT_COL_W'(relCol >> SCALE_LOG2);

  assign firstSample = ((relRow & ROW_MASK) == '0) && ((relCol & COL_MASK) == '0);
  assign lastSample  = ((relRow & ROW_MASK) == ROW_MASK) && ((relCol & COL_MASK) == COL_MASK);
  assign effMode     = restart ? bus.mode : modeLatched;

  assign hit        = accept && inWindow;
  assign emit       = hit && lastSample;
  assign finalBlock = emit && (blockRow == OUT_ROW_LAST) && (blockCol == OUT_COL_LAST);

  assign nextCol = (curCol == COL_MAX) ? '0 : curCol + IN_COL_W'(1);
  assign nextRow = (curCol != COL_MAX) ? curRow :
                   (curRow == ROW_MAX) ? '0 : curRow + IN_ROW_W'(1);

  logic [ACC_W-1:0]  sampleCh [CHANNELS];
  logic [ACC_W-1:0]  fullSum  [CHANNELS];
  logic [ACC_W-1:0]  accNext  [CHANNELS];
  logic [DATA_W-1:0] resultData;

  // NOTE: every always_comb output gets a default before any conditional logic,
  // so no path can leave a value unassigned and infer a latch.
  always_comb begin
    sampleCh   = '{default: '0};
    fullSum    = '{default: '0};
    accNext    = '{default: '0};
    resultData = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sampleCh[c] = ACC_W'(bus.in_data[c*CH_WIDTH +: CH_WIDTH]);
      fullSum[c]  = firstSample ? sampleCh[c] : lineAcc[blockCol][c] + sampleCh[c];
      // Decimation keeps the top-left sample; later samples leave the entry alone.
      accNext[c]  = (firstSample || !effMode) ? fullSum[c] : lineAcc[blockCol][c];
      if (effMode) begin
        resultData[c*CH_WIDTH +: CH_WIDTH] = firstSample ? bus.in_data[c*CH_WIDTH +: CH_WIDTH]
                                                         : lineAcc[blockCol][c][CH_WIDTH-1:0];
      end else begin
        resultData[c*CH_WIDTH +: CH_WIDTH] = CH_WIDTH'((fullSum[c] + ROUND) >> SHIFT);
      end
    end
  end

  // NOTE: state is written only with non-blocking assignments so every register
  // samples pre-edge values and later statements in this block can override earlier ones.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      inRow       <= '0;
      inCol       <= '0;
      modeLatched <= 1'b0;
      // NOTE: the line accumulator is flop-based and one line wide, so it is cleared
      // here like any other register; a RAM-based version would skip this.
      for (int i = 0; i < OUT_WIDTH; i++)
        for (int c = 0; c < CHANNELS; c++)
          lineAcc[i][c] <= '0;
      outValid    <= 1'b0;
      endOfFrame  <= 1'b0;
      outData     <= '0;
      outCol      <= '0;
      outRow      <= '0;
    end else begin
      outValid   <= 1'b0;
      endOfFrame <= 1'b0;

      if (restart) begin
        modeLatched <= bus.mode;
        inRow       <= '0;
        inCol       <= '0;
        for (int i = 0; i < OUT_WIDTH; i++)
          for (int c = 0; c < CHANNELS; c++)
            lineAcc[i][c] <= '0;
      end

      if (accept) begin
        inRow <= nextRow;
        inCol <= nextCol;
      end

      if (hit) begin
        for (int c = 0; c < CHANNELS; c++)
          lineAcc[blockCol][c] <= accNext[c];
      end

      if (emit) begin
        outValid   <= 1'b1;
        outData    <= resultData;
        outCol     <= blockCol;
        outRow     <= blockRow;
        endOfFrame <= finalBlock;
      end

      if (finalBlock)
        state <= DONE;
      else if (restart)
        state <= ACTIVE;
      else if (state == DONE)
        state <= IDLE;
    end
  end

  assign bus.out_valid    = outValid;
  assign bus.out_data     = outData;
  assign bus.out_col      = outCol;
  assign bus.out_row      = outRow;
  assign bus.end_of_frame = endOfFrame;
endmodule

// File: tb/tb_crop_box_downscaler.sv
// Bench for crop_box_downscaler on an 8x6 frame cropped to 4x4 and halved to 2x2:
// table-driven frames, random frames against a block-arithmetic model, restart and reset.
module tb_crop_box_downscaler;
  localparam int CHANNELS     = 3;
  localparam int CH_WIDTH     = 8;
  localparam int INPUT_WIDTH  = 8;
  localparam int INPUT_HEIGHT = 6;
  localparam int CROP_TOP     = 1;
  localparam int CROP_LEFT    = 2;
  localparam int SCALE_LOG2   = 1;
  localparam int OUT_WIDTH    = 2;
  localparam int OUT_HEIGHT   = 2;
  localparam int S            = 1 << SCALE_LOG2;
  localparam int DATA_W       = CHANNELS * CH_WIDTH;
  localparam int NPIX         = INPUT_WIDTH * INPUT_HEIGHT;
  localparam int NVEC         = 6;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                col;
    int                row;
    bit                eof;
    int                stamp;
  } out_event_t;

  typedef struct {
    int                     pattern;
    int                     fill;
    bit                     md;
    int                     gapMax;
    bit                     useTable;
    logic [3:0][DATA_W-1:0] expData;
  } vector_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int tests     = 0;
  int failures  = 0;
  int edgeCount = 0;
  int orphanEof = 0;

  logic [DATA_W-1:0] frame    [INPUT_HEIGHT][INPUT_WIDTH];
  int                pixStamp [INPUT_HEIGHT][INPUT_WIDTH];
  out_event_t        obsQ[$];
  out_event_t        expQ[$];
  vector_t           vectors [NVEC];

  crop_box_downscaler_if #(
    .CHANNELS(CHANNELS), .CH_WIDTH(CH_WIDTH), .OUT_WIDTH(OUT_WIDTH), .OUT_HEIGHT(OUT_HEIGHT)
  ) bus ();

  crop_box_downscaler #(
    .CHANNELS(CHANNELS), .CH_WIDTH(CH_WIDTH),
    .INPUT_WIDTH(INPUT_WIDTH), .INPUT_HEIGHT(INPUT_HEIGHT),
    .CROP_TOP(CROP_TOP), .CROP_LEFT(CROP_LEFT), .SCALE_LOG2(SCALE_LOG2),
    .OUT_WIDTH(OUT_WIDTH), .OUT_HEIGHT(OUT_HEIGHT)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edgeCount <= edgeCount + 1;

  // Outputs settle at the rising edge; sample them on the falling edge.
  always @(negedge clock) begin
    if (bus.out_valid) begin
      obsQ.push_back('{data: bus.out_data, col: int'(bus.out_col), row: int'(bus.out_row),
                       eof: bus.end_of_frame, stamp: edgeCount});
    end
    if (bus.end_of_frame && !bus.out_valid) orphanEof++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failures=%0d", tests, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkQuiet(input string tag);
    check({tag, ".out_valid"},    64'(bus.out_valid),    64'd0);
    check({tag, ".out_data"},     64'(bus.out_data),     64'd0);
    check({tag, ".out_col"},      64'(bus.out_col),      64'd0);
    check({tag, ".out_row"},      64'(bus.out_row),      64'd0);
    check({tag, ".end_of_frame"}, 64'(bus.end_of_frame), 64'd0);
  endtask

  // 0: constant, 1: rounding blocks, 2: row*16+col ramp, 3: random.
  task automatic fillFrame(input int pattern, input int fill);
    logic [CH_WIDTH-1:0] v;
    for (int r = 0; r < INPUT_HEIGHT; r++) begin
      for (int c = 0; c < INPUT_WIDTH; c++) begin
        case (pattern)
          0:       frame[r][c] = {CHANNELS{fill[CH_WIDTH-1:0]}};
          2: begin
            v = CH_WIDTH'(r * 16 + c);
            frame[r][c] = {CHANNELS{v}};
          end
          3:       frame[r][c] = DATA_W'($urandom);
          default: frame[r][c] = 24'h5A5A5A;
        endcase
      end
    end
    if (pattern == 1) begin
      // {blue, green, red}
      frame[1][2] = {8'd0, 8'd0, 8'd1};
      frame[1][3] = {8'd0, 8'd0, 8'd1};
      frame[2][2] = {8'd0, 8'd1, 8'd1};
      frame[2][3] = {8'd0, 8'd1, 8'd2};
      frame[1][4] = {8'd3, 8'd0, 8'd1};
      frame[1][5] = {8'd3, 8'd0, 8'd2};
      frame[2][4] = {8'd3, 8'd0, 8'd2};
      frame[2][5] = {8'd2, 8'd1, 8'd2};
      for (int r = 3; r <= 4; r++)
        for (int c = 2; c <= 5; c++)
          frame[r][c] = 24'hFFFFFF;
    end
  endtask

  // Drives the first nPix raster pixels with random idle gaps; mode flips after the
  // first pixel so only the value seen with start_frame may matter.
  task automatic runFrame(input bit md, input int gapMax, input int nPix, input bit withStart);
    int r, c, gap;
    obsQ.delete();
    for (int i = 0; i < nPix; i++) begin
      r = i / INPUT_WIDTH;
      c = i % INPUT_WIDTH;
      if (i > 0) begin
        gap = int'($urandom_range(gapMax, 0));
        repeat (gap) begin
          bus.in_valid    = 1'b0;
          bus.start_frame = 1'b0;
          bus.mode        = !md;
          bus.in_data     = DATA_W'($urandom);
          @(negedge clock);
        end
      end
      bus.in_valid    = 1'b1;
      bus.in_data     = frame[r][c];
      bus.start_frame = withStart && (i == 0);
      bus.mode        = (i == 0) ? md : !md;
      @(negedge clock);
      pixStamp[r][c] = edgeCount;
    end
    bus.in_valid    = 1'b0;
    bus.start_frame = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  function automatic logic [DATA_W-1:0] blockValue(input bit md, input int br, input int bc);
    logic [DATA_W-1:0] res;
    int sum, top, left;
    res  = '0;
    top  = CROP_TOP + br * S;
    left = CROP_LEFT + bc * S;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      sum = 0;
      for (int dr = 0; dr < S; dr++)
        for (int dc = 0; dc < S; dc++)
          sum += int'(frame[top + dr][left + dc][ch*CH_WIDTH +: CH_WIDTH]);
      if (md) res[ch*CH_WIDTH +: CH_WIDTH] = frame[top][left][ch*CH_WIDTH +: CH_WIDTH];
      else    res[ch*CH_WIDTH +: CH_WIDTH] = CH_WIDTH'((sum + S * S / 2) / (S * S));
    end
    return res;
  endfunction

  // A block is expected once its bottom-right pixel has been sent, in the same
  // cycle that pixel was accepted.
  task automatic buildExpected(input bit md, input int nPix);
    int lastR, lastC;
    expQ.delete();
    for (int br = 0; br < OUT_HEIGHT; br++) begin
      for (int bc = 0; bc < OUT_WIDTH; bc++) begin
        lastR = CROP_TOP + br * S + S - 1;
        lastC = CROP_LEFT + bc * S + S - 1;
        if (lastR * INPUT_WIDTH + lastC < nPix) begin
          expQ.push_back('{data: blockValue(md, br, bc), col: bc, row: br,
                           eof: (br == OUT_HEIGHT - 1) && (bc == OUT_WIDTH - 1),
                           stamp: pixStamp[lastR][lastC]});
        end
      end
    end
  endtask

  task automatic compareRun(input string tag);
    check({tag, ".count"}, 64'(obsQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      check($sformatf("%s[%0d].data", tag, i),  64'(obsQ[i].data),  64'(expQ[i].data));
      check($sformatf("%s[%0d].col", tag, i),   64'(obsQ[i].col),   64'(expQ[i].col));
      check($sformatf("%s[%0d].row", tag, i),   64'(obsQ[i].row),   64'(expQ[i].row));
      check($sformatf("%s[%0d].eof", tag, i),   64'(obsQ[i].eof),   64'(expQ[i].eof));
      check($sformatf("%s[%0d].cycle", tag, i), 64'(obsQ[i].stamp), 64'(expQ[i].stamp));
    end
  endtask

  initial begin
    vectors[0] = '{pattern: 0, fill: 'h10, md: 1'b0, gapMax: 0, useTable: 1'b1,
                   expData: {24'h101010, 24'h101010, 24'h101010, 24'h101010}};
    vectors[1] = '{pattern: 1, fill: 0, md: 1'b0, gapMax: 0, useTable: 1'b1,
                   expData: {24'hFFFFFF, 24'hFFFFFF, 24'h030002, 24'h000101}};
    vectors[2] = '{pattern: 2, fill: 0, md: 1'b1, gapMax: 0, useTable: 1'b1,
                   expData: {24'h343434, 24'h323232, 24'h141414, 24'h121212}};
    vectors[3] = '{pattern: 0, fill: 'h10, md: 1'b0, gapMax: 5, useTable: 1'b1,
                   expData: {24'h101010, 24'h101010, 24'h101010, 24'h101010}};
    vectors[4] = '{pattern: 3, fill: 0, md: 1'b0, gapMax: 3, useTable: 1'b0, expData: '0};
    vectors[5] = '{pattern: 3, fill: 0, md: 1'b1, gapMax: 2, useTable: 1'b0, expData: '0};

    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.start_frame = 1'b0;
    bus.mode        = 1'b0;
    reset_n         = 1'b0;
    repeat (3) @(negedge clock);
    checkQuiet("reset");
    reset_n = 1'b1;
    @(negedge clock);

    for (int k = 0; k < NVEC; k++) begin
      fillFrame(vectors[k].pattern, vectors[k].fill);
      runFrame(vectors[k].md, vectors[k].gapMax, NPIX, 1'b1);
      buildExpected(vectors[k].md, NPIX);
      if (vectors[k].useTable)
        for (int i = 0; i < expQ.size() && i < 4; i++)
          expQ[i].data = vectors[k].expData[i];
      compareRun($sformatf("vec%0d", k));
    end

    // Abort after block (0,0) has been emitted, then restart with a new frame.
    fillFrame(0, 'h10);
    runFrame(1'b0, 0, 2 * INPUT_WIDTH + 5, 1'b1);
    buildExpected(1'b0, 2 * INPUT_WIDTH + 5);
    compareRun("abort_part");
    fillFrame(0, 'h20);
    runFrame(1'b0, 1, NPIX, 1'b1);
    buildExpected(1'b0, NPIX);
    compareRun("restart");

    // One-cycle reset mid-window, with start_frame and a pixel presented alongside it.
    fillFrame(0, 'h33);
    runFrame(1'b0, 0, 2 * INPUT_WIDTH + 5, 1'b1);
    buildExpected(1'b0, 2 * INPUT_WIDTH + 5);
    compareRun("pre_reset");
    reset_n         = 1'b0;
    bus.in_valid    = 1'b1;
    bus.start_frame = 1'b1;
    bus.in_data     = 24'h777777;
    @(negedge clock);
    checkQuiet("mid_reset");
    reset_n         = 1'b1;
    bus.in_valid    = 1'b0;
    bus.start_frame = 1'b0;
    runFrame(1'b0, 0, NPIX, 1'b0);
    check("ignored_without_start", 64'(obsQ.size()), 64'd0);
    fillFrame(3, 0);
    runFrame(1'b0, 2, NPIX, 1'b1);
    buildExpected(1'b0, NPIX);
    compareRun("post_reset");

    check("orphan_end_of_frame", 64'(orphanEof), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
